// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared encodings for the fetch sequencer
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_NEXT   = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RSVD   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_e;

  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - control/fetch bus between core, instMem and the PC sequencer
interface pc_fetch_ctrl_if;
  logic        Stall;
  logic [1:0]  PCSrc;
  logic [31:0] ExtImm;
  logic [25:0] JumpAddr;
  logic [31:0] IDataOut;
  logic [31:0] IAddr;
  logic [31:0] CurPC;
  logic [31:0] PC4;
  logic        InstrValid;
  logic        Commit;
  logic        Halted;
  logic [31:0] RetireCnt;

  // core side: drives control and instruction word, observes the PC
  modport master (
    output Stall, PCSrc, ExtImm, JumpAddr, IDataOut,
    input  IAddr, CurPC, PC4, InstrValid, Commit, Halted, RetireCnt
  );

  // sequencer side
  modport slave (
    input  Stall, PCSrc, ExtImm, JumpAddr, IDataOut,
    output IAddr, CurPC, PC4, InstrValid, Commit, Halted, RetireCnt
  );
endinterface

// File: rtl/npc_calc.sv
// rtl/npc_calc.sv - combinational next-PC selection
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] cur_pc_i,
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] ext_imm_i,
  input  logic [25:0] jump_addr_i,
  output logic [31:0] pc4_o,
  output logic [31:0] next_pc_o
);

  assign pc4_o = cur_pc_i + 32'd4;

  // branch offset is in words; jump keeps the PC4 segment bits; reserved falls back to PC+4
  always_comb begin
    next_pc_o = pc4_o;
    case (pc_src_i)
      PC_BRANCH: next_pc_o = pc4_o + (ext_imm_i << 2);
      PC_JUMP:   next_pc_o = {pc4_o[31:28], jump_addr_i, 2'b00};
      default:   next_pc_o = pc4_o;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC register, boot window, stall/halt sequencing and retire count
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 2,
  parameter int          IMEM_BYTES  = 128,
  parameter logic [5:0]  HALT_OP     = HALT_OP_DEFAULT
) (
  input logic              CLK,
  input logic              Reset,
  pc_fetch_ctrl_if.slave   bus
);

  // BOOT_CYCLES == 0 leaves on the first edge, same as a one-cycle window with counter 0
  localparam logic [7:0]  BOOT_LAST  = (BOOT_CYCLES == 0) ? 8'd0 : 8'(BOOT_CYCLES - 1);
  // fetch address wraps inside instMem; low two bits are always zero
  localparam logic [31:0] IADDR_MASK = 32'(IMEM_BYTES - 1) & ~32'h3;

  state_e      state_q, state_d;
  logic [7:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retire_q, retire_d;
  logic [31:0] pc4;
  logic [31:0] next_pc;
  logic        instr_valid;
  logic        commit;
  logic        halted;
  logic        unused_idata;

  assign unused_idata = ^bus.IDataOut[25:0];

  npc_calc u_npc_calc (
    .cur_pc_i    (pc_q),
    .pc_src_i    (bus.PCSrc),
    .ext_imm_i   (bus.ExtImm),
    .jump_addr_i (bus.JumpAddr),
    .pc4_o       (pc4),
    .next_pc_o   (next_pc)
  );

  // next-state decode: boot countdown, commit/halt handling, same-cycle status outputs
  always_comb begin
    state_d     = state_q;
    boot_cnt_d  = boot_cnt_q;
    pc_d        = pc_q;
    retire_d    = retire_q;
    instr_valid = 1'b0;
    commit      = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_BOOT: begin
        boot_cnt_d = boot_cnt_q + 8'd1;
        if (boot_cnt_q == BOOT_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        instr_valid = 1'b1;
        commit      = !bus.Stall;
        if (commit) begin
          if (retire_q != 32'hFFFF_FFFF) retire_d = retire_q + 32'd1;
          // the halt instruction retires but the PC stays on it
          if (bus.IDataOut[31:26] == HALT_OP) state_d = ST_HALT;
          else                               pc_d    = next_pc;
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // architectural state registers, cleared asynchronously
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_BOOT;
      boot_cnt_q <= 8'd0;
      pc_q       <= RESET_PC;
      retire_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      retire_q   <= retire_d;
    end
  end

  assign bus.IAddr      = pc_q & IADDR_MASK;
  assign bus.CurPC      = pc_q;
  assign bus.PC4        = pc4;
  assign bus.InstrValid = instr_valid;
  assign bus.Commit     = commit;
  assign bus.Halted     = halted;
  assign bus.RetireCnt  = retire_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // reference model: boot countdown, halted flag, full PC, retire count
  int          m_boot_left;
  bit          m_halted;
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic model_reset();
    m_boot_left = 2;
    m_halted    = 1'b0;
    m_pc        = 32'h0;
    m_cnt       = 32'h0;
  endtask

  task automatic model_edge();
    if (!Reset) model_reset();
    else if (m_boot_left > 0) m_boot_left--;
    else if (!m_halted && !bus.Stall) begin
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (bus.IDataOut[31:26] == 6'h3F) m_halted = 1'b1;
      else begin
        case (bus.PCSrc)
          2'd1:    m_pc = m_pc + 32'd4 + bus.ExtImm * 32'd4;
          2'd2:    m_pc = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(bus.JumpAddr) * 32'd4);
          default: m_pc = m_pc + 32'd4;
        endcase
      end
    end
  endtask

  // inputs are driven 1 time unit after the rising edge; outputs are sampled at the falling edge
  task automatic apply(input logic stall, input logic [1:0] src, input logic [31:0] ext,
                       input logic [25:0] jaddr, input logic [31:0] instr);
    bus.Stall    = stall;
    bus.PCSrc    = src;
    bus.ExtImm   = ext;
    bus.JumpAddr = jaddr;
    bus.IDataOut = instr;
    #4;
  endtask

  task automatic clock_edge();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
    clock_edge();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    model_reset();
    apply(1'b1, 2'd1, 32'h5, 26'h3, 32'hFC00_0000);
    checks++; if (bus.CurPC !== 32'h0) begin failures++; $display("FAIL reset_curpc act=%h exp=%h", bus.CurPC, 32'h0); end
    checks++; if (bus.IAddr !== 32'h0) begin failures++; $display("FAIL reset_iaddr act=%h exp=%h", bus.IAddr, 32'h0); end
    checks++; if (bus.InstrValid !== 1'b0 || bus.Commit !== 1'b0 || bus.Halted !== 1'b0)
      begin failures++; $display("FAIL reset_flags act=%b%b%b exp=000", bus.InstrValid, bus.Commit, bus.Halted); end
    checks++; if (bus.RetireCnt !== 32'h0) begin failures++; $display("FAIL reset_cnt act=%0d exp=0", bus.RetireCnt); end
    clock_edge();
    Reset = 1'b1;
  endtask

  task automatic test_boot();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
      checks++; if (bus.InstrValid !== 1'b0 || bus.IAddr !== 32'h0)
        begin failures++; $display("FAIL boot_idle%0d act=v%b a=%h exp=v0 a=0", i, bus.InstrValid, bus.IAddr); end
      clock_edge();
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
      checks++; if (bus.InstrValid !== 1'b1 || bus.Commit !== 1'b1)
        begin failures++; $display("FAIL boot_run%0d act=v%b c%b exp=v1 c1", i, bus.InstrValid, bus.Commit); end
      clock_edge();
    end
    apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
    checks++; if (bus.IAddr !== 32'h0C) begin failures++; $display("FAIL boot_iaddr act=%h exp=%h", bus.IAddr, 32'h0C); end
    checks++; if (bus.RetireCnt !== 32'd3) begin failures++; $display("FAIL boot_cnt act=%0d exp=3", bus.RetireCnt); end
  endtask

  task automatic test_branch_jump();
    apply(1'b0, 2'd2, 32'h0, 26'h2, 32'h0);
    clock_edge();
    apply(1'b0, 2'd1, 32'hFFFF_FFFE, 26'h0, 32'h0);
    checks++; if (bus.CurPC !== 32'h08) begin failures++; $display("FAIL jump_to_08 act=%h exp=%h", bus.CurPC, 32'h08); end
    checks++; if (bus.PC4 !== 32'h0C) begin failures++; $display("FAIL pc4 act=%h exp=%h", bus.PC4, 32'h0C); end
    clock_edge();
    apply(1'b0, 2'd2, 32'h0, 26'h10, 32'h0);
    checks++; if (bus.CurPC !== 32'h04) begin failures++; $display("FAIL branch_back act=%h exp=%h", bus.CurPC, 32'h04); end
    clock_edge();
    apply(1'b0, 2'd2, 32'h0, 26'h4, 32'h0);
    checks++; if (bus.CurPC !== 32'h40) begin failures++; $display("FAIL jump_40 act=%h exp=%h", bus.CurPC, 32'h40); end
    clock_edge();
  endtask

  task automatic test_stall();
    logic [31:0] cnt0;
    cnt0 = bus.RetireCnt;
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 2'($urandom_range(0, 3)), $urandom, 26'($urandom), 32'h0);
      checks++; if (bus.Commit !== 1'b0) begin failures++; $display("FAIL stall_commit%0d act=%b exp=0", i, bus.Commit); end
      checks++; if (bus.CurPC !== 32'h10 || bus.RetireCnt !== m_cnt)
        begin failures++; $display("FAIL stall_frozen%0d act=%h/%0d exp=%h/%0d", i, bus.CurPC, bus.RetireCnt, 32'h10, m_cnt); end
      clock_edge();
    end
    apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
    clock_edge();
    apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
    checks++; if (bus.CurPC !== 32'h14) begin failures++; $display("FAIL stall_release act=%h exp=%h", bus.CurPC, 32'h14); end
    checks++; if (bus.RetireCnt !== cnt0 + 32'd1) begin failures++; $display("FAIL stall_cnt act=%0d exp=%0d", bus.RetireCnt, cnt0 + 32'd1); end
  endtask

  task automatic test_wrap();
    apply(1'b0, 2'd2, 32'h0, 26'h1F, 32'h0);
    clock_edge();
    apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
    checks++; if (bus.CurPC !== 32'h7C || bus.IAddr !== 32'h7C)
      begin failures++; $display("FAIL wrap_pre act=%h/%h exp=7c/7c", bus.CurPC, bus.IAddr); end
    clock_edge();
    apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
    checks++; if (bus.CurPC !== 32'h80) begin failures++; $display("FAIL wrap_curpc act=%h exp=%h", bus.CurPC, 32'h80); end
    checks++; if (bus.IAddr !== 32'h00) begin failures++; $display("FAIL wrap_iaddr act=%h exp=%h", bus.IAddr, 32'h0); end
  endtask

  task automatic test_halt();
    logic [31:0] cnt0;
    apply(1'b0, 2'd2, 32'h0, 26'h7, 32'h0);
    clock_edge();
    cnt0 = m_cnt;
    apply(1'b1, 2'd0, 32'h0, 26'h0, 32'hFC00_0000);
    checks++; if (bus.CurPC !== 32'h1C || bus.Commit !== 1'b0 || bus.Halted !== 1'b0)
      begin failures++; $display("FAIL halt_stalled act=%h c%b h%b exp=1c c0 h0", bus.CurPC, bus.Commit, bus.Halted); end
    clock_edge();
    apply(1'b0, 2'd0, 32'h0, 26'h0, 32'hFC00_0000);
    checks++; if (bus.Halted !== 1'b0 || bus.Commit !== 1'b1)
      begin failures++; $display("FAIL halt_unstall act=h%b c%b exp=h0 c1", bus.Halted, bus.Commit); end
    clock_edge();
    for (int i = 0; i < 4; i++) begin
      apply(1'($urandom_range(0, 1)), 2'd1, 32'h10, 26'h3, 32'h0);
      checks++; if (bus.Halted !== 1'b1 || bus.InstrValid !== 1'b0 || bus.Commit !== 1'b0)
        begin failures++; $display("FAIL halt_flags%0d act=h%b v%b c%b exp=h1 v0 c0", i, bus.Halted, bus.InstrValid, bus.Commit); end
      checks++; if (bus.CurPC !== 32'h1C || bus.RetireCnt !== cnt0 + 32'd1)
        begin failures++; $display("FAIL halt_hold%0d act=%h/%0d exp=1c/%0d", i, bus.CurPC, bus.RetireCnt, cnt0 + 32'd1); end
      clock_edge();
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 2'd0, 32'h0, 26'h0, 32'h0);
      clock_edge();
    end
    apply(1'b0, 2'd2, 32'h0, 26'h9, 32'h0);
    clock_edge();
    bus.Stall = 1'b0;
    #2;
    checks++; if (bus.CurPC !== 32'h24 || bus.InstrValid !== 1'b1)
      begin failures++; $display("FAIL midrun_pre act=%h v%b exp=24 v1", bus.CurPC, bus.InstrValid); end
    Reset = 1'b0;
    #1;
    checks++; if (bus.CurPC !== 32'h0 || bus.RetireCnt !== 32'h0)
      begin failures++; $display("FAIL midrun_reset act=%h/%0d exp=0/0", bus.CurPC, bus.RetireCnt); end
    checks++; if (bus.InstrValid !== 1'b0 || bus.Commit !== 1'b0)
      begin failures++; $display("FAIL midrun_flags act=v%b c%b exp=v0 c0", bus.InstrValid, bus.Commit); end
    clock_edge();
    Reset = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] instr;
    logic        run;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      instr = ($urandom_range(0, 29) == 0) ? 32'hFC00_0000 | ($urandom & 32'h03FF_FFFF) : $urandom & 32'hF7FF_FFFF;
      apply($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), $urandom, 26'($urandom), instr);
      run = (m_boot_left == 0) && !m_halted;
      checks++; if (bus.CurPC !== m_pc || bus.PC4 !== m_pc + 32'd4 || bus.IAddr !== (m_pc % 32'd128))
        begin failures++; $display("FAIL rand_pc%0d act=%h/%h/%h exp=%h", i, bus.CurPC, bus.PC4, bus.IAddr, m_pc); end
      checks++; if (bus.RetireCnt !== m_cnt)
        begin failures++; $display("FAIL rand_cnt%0d act=%0d exp=%0d", i, bus.RetireCnt, m_cnt); end
      checks++; if (bus.InstrValid !== run || bus.Commit !== (run && !bus.Stall) || bus.Halted !== m_halted)
        begin failures++; $display("FAIL rand_flags%0d act=v%b c%b h%b exp=v%b c%b h%b", i, bus.InstrValid, bus.Commit,
                                   bus.Halted, run, run && !bus.Stall, m_halted); end
      clock_edge();
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_branch_jump();
    test_stall();
    test_wrap();
    test_halt();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
